// File: rtl/modulo_controlador_rolhas.sv
// modulo_controlador_rolhas: corking-station sequencer that owns the cork stock REG_R
// Ports:
//   CLK, RST (async, active-high)
//   START, SENSOR_GARRAFA, VEDA_OK, ACK_DISP, DISP_VAZIO, CLR_ALARME : line and peripheral inputs
//   REG_R[6:0] stock; VEDAR, REQ_DISP, ALARME decoded from state; EVT_VEDADA 1-cycle pulse; ESTADO[2:0] state code
module modulo_controlador_rolhas #(
  parameter int MAX_ROLHAS = 99,
  parameter int LIMIAR     = 5,
  parameter int LOTE       = 15,
  parameter int TIMEOUT    = 63
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       SENSOR_GARRAFA,
  input  logic       VEDA_OK,
  input  logic       ACK_DISP,
  input  logic       DISP_VAZIO,
  input  logic       CLR_ALARME,
  output logic [6:0] REG_R,
  output logic       VEDAR,
  output logic       REQ_DISP,
  output logic       ALARME,
  output logic       EVT_VEDADA,
  output logic [2:0] ESTADO
);
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ESPERA     = 3'd1,
    VEDANDO    = 3'd2,
    REABASTECE = 3'd3,
    FALHA      = 3'd4
  } estado_t;
  estado_t estado, prox;
  logic [5:0] timer, prox_timer;
  logic [6:0] prox_r;
  logic       prox_evt;
  logic [7:0] soma;
  // 8-bit sum so a refill near the ceiling saturates instead of wrapping
  assign soma = {1'b0, REG_R} + 8'(LOTE);
  always_comb begin
    prox       = estado;
    prox_r     = REG_R;
    prox_timer = timer;
    prox_evt   = 1'b0;
    case (estado)
      IDLE: prox = START ? ESPERA : IDLE;
      ESPERA:
        if (!START) prox = IDLE;
        else if (REG_R <= 7'(LIMIAR) && !DISP_VAZIO) prox = REABASTECE;
        else if (REG_R == '0 && DISP_VAZIO) prox = FALHA;
        else if (SENSOR_GARRAFA) begin
          prox       = VEDANDO;
          prox_timer = '0;
        end
      VEDANDO:
        if (VEDA_OK) begin
          prox     = ESPERA;
          prox_r   = (REG_R == '0) ? REG_R : REG_R - 7'd1;
          prox_evt = 1'b1;
        end else if (timer == 6'(TIMEOUT - 1)) prox = FALHA;
        else prox_timer = timer + 6'd1;
      REABASTECE:
        if (ACK_DISP) begin
          prox   = ESPERA;
          prox_r = (soma > 8'(MAX_ROLHAS)) ? 7'(MAX_ROLHAS) : soma[6:0];
        end else if (DISP_VAZIO) prox = (REG_R == '0) ? FALHA : ESPERA;
      FALHA: prox = CLR_ALARME ? IDLE : FALHA;
      default: prox = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      estado     <= IDLE;
      REG_R      <= '0;
      timer      <= '0;
      EVT_VEDADA <= 1'b0;
    end else begin
      estado     <= prox;
      REG_R      <= prox_r;
      timer      <= prox_timer;
      EVT_VEDADA <= prox_evt;
    end
  end
  assign VEDAR    = (estado == VEDANDO);
  assign REQ_DISP = (estado == REABASTECE);
  assign ALARME   = (estado == FALHA);
  assign ESTADO   = estado;
endmodule

// File: tb/tb_modulo_controlador_rolhas.sv
// tb_modulo_controlador_rolhas: directed self-checking bench for the corking sequencer
module tb_modulo_controlador_rolhas;
  logic clk = 1'b0, rst = 1'b0;
  logic start = 0, sensor = 0, veda_ok = 0, ack = 0, vazio = 0, clr = 0;
  logic start2 = 0, ack2 = 0, z = 0;
  logic [6:0] reg_r, reg_r2;
  logic vedar, req, alarme, evt, vedar2, req2, alarme2, evt2;
  logic [2:0] estado, estado2;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  modulo_controlador_rolhas dut (
    .CLK(clk), .RST(rst), .START(start), .SENSOR_GARRAFA(sensor), .VEDA_OK(veda_ok),
    .ACK_DISP(ack), .DISP_VAZIO(vazio), .CLR_ALARME(clr), .REG_R(reg_r), .VEDAR(vedar),
    .REQ_DISP(req), .ALARME(alarme), .EVT_VEDADA(evt), .ESTADO(estado)
  );

  // second instance: big batch and high threshold to exercise the saturating refill
  modulo_controlador_rolhas #(.LOTE(97), .LIMIAR(98)) dut2 (
    .CLK(clk), .RST(rst), .START(start2), .SENSOR_GARRAFA(z), .VEDA_OK(z),
    .ACK_DISP(ack2), .DISP_VAZIO(z), .CLR_ALARME(z), .REG_R(reg_r2), .VEDAR(vedar2),
    .REQ_DISP(req2), .ALARME(alarme2), .EVT_VEDADA(evt2), .ESTADO(estado2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    checks++;
    if (estado !== 3'd0 || reg_r !== 7'd0) begin
      failures++;
      $display("FAIL reset_state: estado=%0d reg_r=%0d expected 0 0", estado, reg_r);
    end
    checks++;
    if ({vedar, req, alarme, evt} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected 0000", {vedar, req, alarme, evt});
    end
    checks++;
    if (estado2 !== 3'd0 || reg_r2 !== 7'd0) begin
      failures++;
      $display("FAIL reset_dut2: estado=%0d reg_r=%0d expected 0 0", estado2, reg_r2);
    end
  endtask

  task automatic test_refill;
    start = 1;
    tick;
    checks++;
    if (estado !== 3'd1) begin
      failures++;
      $display("FAIL t1_espera: estado=%0d expected 1", estado);
    end
    tick;
    checks++;
    if (estado !== 3'd3 || req !== 1'b1) begin
      failures++;
      $display("FAIL t1_reabastece: estado=%0d req=%0d expected 3 1", estado, req);
    end
    ack = 1;
    tick;
    ack = 0;
    checks++;
    if (reg_r !== 7'd15 || estado !== 3'd1 || req !== 1'b0) begin
      failures++;
      $display("FAIL t1_ack: reg_r=%0d estado=%0d req=%0d expected 15 1 0", reg_r, estado, req);
    end
  endtask

  task automatic test_bottles;
    sensor = 1;
    tick;
    sensor = 0;
    checks++;
    if (vedar !== 1'b1 || estado !== 3'd2) begin
      failures++;
      $display("FAIL t2_vedar: vedar=%0d estado=%0d expected 1 2", vedar, estado);
    end
    veda_ok = 1;
    tick;
    veda_ok = 0;
    checks++;
    if (reg_r !== 7'd14 || evt !== 1'b1 || estado !== 3'd1) begin
      failures++;
      $display("FAIL t2_vedada: reg_r=%0d evt=%0d estado=%0d expected 14 1 1", reg_r, evt, estado);
    end
    tick;
    checks++;
    if (evt !== 1'b0 || reg_r !== 7'd14) begin
      failures++;
      $display("FAIL t2_evt_pulse: evt=%0d reg_r=%0d expected 0 14", evt, reg_r);
    end
    veda_ok = 1;
    tick;
    veda_ok = 0;
    checks++;
    if (reg_r !== 7'd14 || evt !== 1'b0 || estado !== 3'd1) begin
      failures++;
      $display("FAIL t2_veda_ok_ignored: reg_r=%0d evt=%0d estado=%0d expected 14 0 1", reg_r, evt, estado);
    end
    for (int i = 0; i < 9; i++) begin
      sensor = 1;
      tick;
      sensor = 0;
      checks++;
      if (vedar !== 1'b1) begin
        failures++;
        $display("FAIL t2_loop_vedar[%0d]: vedar=%0d expected 1", i, vedar);
      end
      veda_ok = 1;
      tick;
      veda_ok = 0;
    end
    checks++;
    if (reg_r !== 7'd5 || estado !== 3'd1) begin
      failures++;
      $display("FAIL t2_stock5: reg_r=%0d estado=%0d expected 5 1", reg_r, estado);
    end
  endtask

  task automatic test_refill_priority;
    sensor = 1;
    tick;
    sensor = 0;
    checks++;
    if (estado !== 3'd3 || vedar !== 1'b0 || req !== 1'b1) begin
      failures++;
      $display("FAIL t3_priority: estado=%0d vedar=%0d req=%0d expected 3 0 1", estado, vedar, req);
    end
    ack = 1;
    tick;
    ack = 0;
    checks++;
    if (reg_r !== 7'd20 || estado !== 3'd1) begin
      failures++;
      $display("FAIL t3_refill20: reg_r=%0d estado=%0d expected 20 1", reg_r, estado);
    end
  endtask

  task automatic test_saturation;
    start2 = 1;
    tick;
    tick;
    ack2 = 1;
    tick;
    ack2 = 0;
    checks++;
    if (reg_r2 !== 7'd97 || estado2 !== 3'd1) begin
      failures++;
      $display("FAIL t3_first_batch: reg_r=%0d estado=%0d expected 97 1", reg_r2, estado2);
    end
    tick;
    checks++;
    if (estado2 !== 3'd3) begin
      failures++;
      $display("FAIL t3_second_req: estado=%0d expected 3", estado2);
    end
    ack2 = 1;
    tick;
    ack2 = 0;
    checks++;
    if (reg_r2 !== 7'd99) begin
      failures++;
      $display("FAIL t3_saturate: reg_r=%0d expected 99", reg_r2);
    end
    tick;
    checks++;
    if (estado2 !== 3'd1 || reg_r2 !== 7'd99) begin
      failures++;
      $display("FAIL t3_above_limiar: estado=%0d reg_r=%0d expected 1 99", estado2, reg_r2);
    end
  endtask

  task automatic test_timeout;
    sensor = 1;
    tick;
    sensor = 0;
    repeat (62) tick;
    checks++;
    if (estado !== 3'd2 || alarme !== 1'b0) begin
      failures++;
      $display("FAIL t4_before_timeout: estado=%0d alarme=%0d expected 2 0", estado, alarme);
    end
    tick;
    checks++;
    if (estado !== 3'd4 || alarme !== 1'b1 || vedar !== 1'b0 || reg_r !== 7'd20) begin
      failures++;
      $display("FAIL t4_timeout: estado=%0d alarme=%0d vedar=%0d reg_r=%0d expected 4 1 0 20", estado, alarme, vedar, reg_r);
    end
    clr = 1;
    tick;
    clr = 0;
    checks++;
    if (estado !== 3'd0 || alarme !== 1'b0 || reg_r !== 7'd20) begin
      failures++;
      $display("FAIL t4_clear: estado=%0d alarme=%0d reg_r=%0d expected 0 0 20", estado, alarme, reg_r);
    end
  endtask

  task automatic test_starvation;
    vazio = 1;
    tick;
    for (int i = 0; i < 17; i++) begin
      sensor = 1;
      tick;
      sensor = 0;
      veda_ok = 1;
      tick;
      veda_ok = 0;
    end
    checks++;
    if (reg_r !== 7'd3 || estado !== 3'd1) begin
      failures++;
      $display("FAIL t5_stock3: reg_r=%0d estado=%0d expected 3 1", reg_r, estado);
    end
    for (int i = 0; i < 3; i++) begin
      sensor = 1;
      tick;
      sensor = 0;
      checks++;
      if (vedar !== 1'b1) begin
        failures++;
        $display("FAIL t5_low_vedar[%0d]: vedar=%0d expected 1", i, vedar);
      end
      veda_ok = 1;
      tick;
      veda_ok = 0;
    end
    checks++;
    if (reg_r !== 7'd0) begin
      failures++;
      $display("FAIL t5_stock0: reg_r=%0d expected 0", reg_r);
    end
    sensor = 1;
    tick;
    sensor = 0;
    checks++;
    if (estado !== 3'd4 || alarme !== 1'b1) begin
      failures++;
      $display("FAIL t5_falha: estado=%0d alarme=%0d expected 4 1", estado, alarme);
    end
    clr = 1;
    vazio = 0;
    tick;
    clr = 0;
    tick;
    tick;
    vazio = 1;
    tick;
    checks++;
    if (estado !== 3'd4 || reg_r !== 7'd0) begin
      failures++;
      $display("FAIL t5_reabastece_vazio: estado=%0d reg_r=%0d expected 4 0", estado, reg_r);
    end
    clr = 1;
    vazio = 0;
    tick;
    clr = 0;
    tick;
    tick;
    ack = 1;
    vazio = 1;
    tick;
    ack = 0;
    vazio = 0;
    checks++;
    if (reg_r !== 7'd15 || estado !== 3'd1) begin
      failures++;
      $display("FAIL t5_ack_and_vazio: reg_r=%0d estado=%0d expected 15 1", reg_r, estado);
    end
  endtask

  task automatic test_async_reset;
    sensor = 1;
    tick;
    sensor = 0;
    #2 rst = 1;
    #1;
    checks++;
    if (estado !== 3'd0 || reg_r !== 7'd0 || {vedar, req, alarme, evt} !== 4'b0000) begin
      failures++;
      $display("FAIL t6_async: estado=%0d reg_r=%0d outs=%b expected 0 0 0000", estado, reg_r, {vedar, req, alarme, evt});
    end
    tick;
    rst = 0;
    veda_ok = 1;
    tick;
    veda_ok = 0;
    checks++;
    if (reg_r !== 7'd0 || evt !== 1'b0 || estado !== 3'd1) begin
      failures++;
      $display("FAIL t6_veda_ok_after_reset: reg_r=%0d evt=%0d estado=%0d expected 0 0 1", reg_r, evt, estado);
    end
  endtask

  initial begin
    test_reset;
    test_refill;
    test_bottles;
    test_refill_priority;
    test_saturation;
    test_timeout;
    test_starvation;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
